// File: rtl/axi_rd_pkg.sv
// Shared types and width constants for the AXI read path.
//   AXI_RD_ADDR_W : byte-address width used by the read master and sequencer
//   AXI_RD_SIZE_W : chunk/job size width in data beats
//   AXI_RD_CNT_W  : chunk-count width per strided descriptor
//   seq_state_t   : sequencer FSM states
//   rd_desc_t     : strided-read descriptor at the default widths
package axi_rd_pkg;

    localparam int unsigned AXI_RD_ADDR_W = 64;
    localparam int unsigned AXI_RD_SIZE_W = 32;
    localparam int unsigned AXI_RD_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        NEXT  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [AXI_RD_ADDR_W-1:0] base;
        logic [AXI_RD_ADDR_W-1:0] stride;
        logic [AXI_RD_CNT_W-1:0]  count;
        logic [AXI_RD_SIZE_W-1:0] size;
    } rd_desc_t;

endpackage

// File: rtl/axi_rd_desc_slot.sv
// One-entry valid/ready holding register.
//   clk, rst            : clock, synchronous active-high reset (slot empties)
//   in_valid / in_ready : producer handshake; ready whenever the slot is empty
//   in_data             : captured only on the handshake
//   out_valid / out_data: slot contents
//   pop                 : consumer takes the entry this cycle
module axi_rd_desc_slot
    import axi_rd_pkg::*;
#(
    parameter type T = rd_desc_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    output T     out_data,
    input  logic pop
);

    logic full_q;
    T     data_q;
    logic push;

    assign in_ready  = ~full_q;
    assign push      = in_valid & in_ready;
    assign out_valid = full_q;
    assign out_data  = data_q;

    // A push in the same cycle as a pop keeps the slot full with new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            if (push)
                full_q <= 1'b1;
            else if (pop)
                full_q <= 1'b0;
            if (push)
                data_q <= in_data;
        end
    end

endmodule

// File: rtl/axi_rd_seq.sv
// Strided-read command sequencer feeding the AXI read master.
// Each accepted descriptor (base, stride, count, size) becomes `count`
// read-master jobs at base, base+stride, ... with `size` beats each.
//   clk, rst                 : clock, synchronous active-high reset
//   desc_valid_i/desc_ready_o: descriptor handshake (ready = pending slot empty)
//   desc_base_i/stride_i/count_i/size_i : descriptor fields
//   ctrl_start_o             : one-cycle job start
//   ctrl_offset_o/ctrl_size_o: job offset and beats, held until the next start
//   ctrl_done_i              : job-complete pulse, honoured only while waiting
//   desc_done_o              : one-cycle pulse per finished descriptor
//   busy_o                   : descriptor in progress
//   chunk_idx_o              : index of current chunk (debug)
module axi_rd_seq
    import axi_rd_pkg::*;
#(
    parameter int unsigned C_ADDR_W = AXI_RD_ADDR_W,
    parameter int unsigned C_SIZE_W = AXI_RD_SIZE_W,
    parameter int unsigned C_CNT_W  = AXI_RD_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                desc_valid_i,
    output logic                desc_ready_o,
    input  logic [C_ADDR_W-1:0] desc_base_i,
    input  logic [C_ADDR_W-1:0] desc_stride_i,
    input  logic [C_CNT_W-1:0]  desc_count_i,
    input  logic [C_SIZE_W-1:0] desc_size_i,
    output logic                ctrl_start_o,
    output logic [C_ADDR_W-1:0] ctrl_offset_o,
    output logic [C_SIZE_W-1:0] ctrl_size_o,
    input  logic                ctrl_done_i,
    output logic                desc_done_o,
    output logic                busy_o,
    output logic [C_CNT_W-1:0]  chunk_idx_o
);

    typedef struct packed {
        logic [C_ADDR_W-1:0] base;
        logic [C_ADDR_W-1:0] stride;
        logic [C_CNT_W-1:0]  count;
        logic [C_SIZE_W-1:0] size;
    } desc_t;

    desc_t      desc_in;
    desc_t      pend;
    logic       pend_vld;
    logic       pend_pop;
    logic       pend_runnable;
    logic       load;

    seq_state_t state_q, state_d;

    logic [C_ADDR_W-1:0] addr_q;
    logic [C_ADDR_W-1:0] stride_q;
    logic [C_ADDR_W-1:0] offset_q;
    logic [C_SIZE_W-1:0] size_q;
    logic [C_CNT_W-1:0]  remain_q;
    logic [C_CNT_W-1:0]  idx_q;
    logic                ddone_q;

    assign desc_in = '{base:   desc_base_i,
                       stride: desc_stride_i,
                       count:  desc_count_i,
                       size:   desc_size_i};

    axi_rd_desc_slot #(.T(desc_t)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (desc_valid_i),
        .in_ready  (desc_ready_o),
        .in_data   (desc_in),
        .out_valid (pend_vld),
        .out_data  (pend),
        .pop       (pend_pop)
    );

    // Empty descriptors are consumed in IDLE without ever reaching START.
    assign pend_runnable = (pend.count != '0) && (pend.size != '0);
    assign pend_pop      = (state_q == IDLE) && pend_vld;
    assign load          = pend_pop && pend_runnable;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (ctrl_done_i) state_d = NEXT;
            NEXT:    state_d = (remain_q != '0) ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // addr_q runs one chunk ahead of offset_q once a job completes; offset_q
    // is only refreshed on the way into START so the read master sees a
    // value that is stable from one start to the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            stride_q <= '0;
            offset_q <= '0;
            size_q   <= '0;
            remain_q <= '0;
            idx_q    <= '0;
            ddone_q  <= 1'b0;
        end else begin
            ddone_q <= (pend_pop && !pend_runnable) ||
                       (state_q == NEXT && remain_q == '0);

            if (load) begin
                addr_q   <= pend.base;
                stride_q <= pend.stride;
                offset_q <= pend.base;
                size_q   <= pend.size;
                remain_q <= pend.count;
                idx_q    <= '0;
            end

            if (state_q == WAIT && ctrl_done_i) begin
                addr_q   <= addr_q + stride_q;
                remain_q <= remain_q - C_CNT_W'(1);
                idx_q    <= idx_q + C_CNT_W'(1);
            end

            if (state_q == NEXT && remain_q != '0)
                offset_q <= addr_q;
        end
    end

    assign ctrl_start_o  = (state_q == START);
    assign ctrl_offset_o = offset_q;
    assign ctrl_size_o   = size_q;
    assign desc_done_o   = ddone_q;
    assign busy_o        = (state_q != IDLE);
    assign chunk_idx_o   = idx_q;

endmodule

// File: tb/tb_axi_rd_seq.sv
`timescale 1ns/1ps
module tb_axi_rd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        desc_valid_i = 1'b0;
    logic        desc_ready_o;
    logic [63:0] desc_base_i = '0;
    logic [63:0] desc_stride_i = '0;
    logic [15:0] desc_count_i = '0;
    logic [31:0] desc_size_i = '0;
    logic        ctrl_start_o;
    logic [63:0] ctrl_offset_o;
    logic [31:0] ctrl_size_o;
    logic        ctrl_done_i;
    logic        desc_done_o;
    logic        busy_o;
    logic [15:0] chunk_idx_o;

    logic resp_done = 1'b0;
    logic spur_done = 1'b0;
    assign ctrl_done_i = resp_done | spur_done;

    axi_rd_seq dut (
        .clk           (clk),
        .rst           (rst),
        .desc_valid_i  (desc_valid_i),
        .desc_ready_o  (desc_ready_o),
        .desc_base_i   (desc_base_i),
        .desc_stride_i (desc_stride_i),
        .desc_count_i  (desc_count_i),
        .desc_size_i   (desc_size_i),
        .ctrl_start_o  (ctrl_start_o),
        .ctrl_offset_o (ctrl_offset_o),
        .ctrl_size_o   (ctrl_size_o),
        .ctrl_done_i   (ctrl_done_i),
        .desc_done_o   (desc_done_o),
        .busy_o        (busy_o),
        .chunk_idx_o   (chunk_idx_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected job stream: one entry per chunk, or one marker per empty descriptor.
    typedef struct {
        bit          zero;
        logic [63:0] off;
        logic [31:0] size;
        int          idx;
        bit          first;
        bit          last;
        bit          gap3;
        bit          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   pend_ddone = 0;
    int   last_done_cyc = -100;
    int   resp_dly = 0;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_push(input logic [63:0] b, input logic [63:0] st,
                              input logic [15:0] c, input logic [31:0] z,
                              input bit g3, input bit lat);
        exp_t e;
        e = '{default: 0};
        if (c == 0 || z == 0) begin
            e.zero = 1'b1;
            e.lat  = lat;
            e.acc  = cyc;
            exp_q.push_back(e);
        end else begin
            for (int i = 0; i < int'(c); i++) begin
                e.zero  = 1'b0;
                e.off   = b + st * 64'(i);
                e.size  = z;
                e.idx   = i;
                e.first = (i == 0);
                e.last  = (i == int'(c) - 1);
                e.gap3  = g3 && (i == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    // Read-master stand-in plus output monitor; runs 1ns after each negedge.
    initial begin : resp
        int   timer;
        bit   cur_last;
        bit   ok;
        exp_t e;
        timer = 0;
        cur_last = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            resp_done = 1'b0;
            if (rst) begin
                exp_q.delete();
                timer = 0;
                pend_ddone = 0;
                continue;
            end
            if (timer > 0) begin
                timer--;
                if (timer == 0) begin
                    resp_done = 1'b1;
                    last_done_cyc = cyc;
                    if (cur_last) pend_ddone++;
                end
            end
            if (ctrl_start_o) begin
                ok = (exp_q.size() != 0) && !exp_q[0].zero;
                chk("start_expected", 64'(ok), 64'd1);
                if (ok) begin
                    e = exp_q.pop_front();
                    chk("offset", ctrl_offset_o, e.off);
                    chk("size", 64'(ctrl_size_o), 64'(e.size));
                    chk("chunk_idx", 64'(chunk_idx_o), 64'(e.idx));
                    if (!e.first)
                        chk("gap_intra", 64'(cyc - last_done_cyc), 64'd2);
                    else if (e.gap3)
                        chk("gap_pending", 64'(cyc - last_done_cyc), 64'd3);
                    cur_last = e.last;
                    timer = (resp_dly != 0) ? resp_dly : int'($urandom_range(1, 8));
                end
            end
            if (desc_done_o) begin
                ok = 1'b0;
                if (pend_ddone > 0) begin
                    pend_ddone--;
                    ok = 1'b1;
                end else if (exp_q.size() != 0 && exp_q[0].zero) begin
                    e = exp_q.pop_front();
                    ok = 1'b1;
                    if (e.lat) chk("zero_done_lat", 64'(cyc - e.acc), 64'd2);
                end
                chk("ddone_expected", 64'(ok), 64'd1);
            end
        end
    end

    task automatic send(input logic [63:0] b, input logic [63:0] st,
                        input logic [15:0] c, input logic [31:0] z,
                        input bit g3, input bit lat);
        int n;
        n = 0;
        while (!desc_ready_o) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                chk("ready_timeout", 64'(desc_ready_o), 64'd1);
                return;
            end
        end
        desc_valid_i  = 1'b1;
        desc_base_i   = b;
        desc_stride_i = st;
        desc_count_i  = c;
        desc_size_i   = z;
        model_push(b, st, c, z, g3, lat);
        @(negedge clk);
        // Garbage after the handshake must not leak into the stored descriptor.
        desc_valid_i  = 1'b0;
        desc_base_i   = {$urandom, $urandom};
        desc_stride_i = {$urandom, $urandom};
        desc_count_i  = 16'($urandom);
        desc_size_i   = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 || pend_ddone != 0 || busy_o || !desc_ready_o) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                chk("idle_timeout", 64'(exp_q.size()), 64'd0);
                return;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_start"},  64'(ctrl_start_o), 64'd0);
        chk({tag, "_offset"}, ctrl_offset_o, 64'd0);
        chk({tag, "_size"},   64'(ctrl_size_o), 64'd0);
        chk({tag, "_ddone"},  64'(desc_done_o), 64'd0);
        chk({tag, "_busy"},   64'(busy_o), 64'd0);
        chk({tag, "_idx"},    64'(chunk_idx_o), 64'd0);
        chk({tag, "_ready"},  64'(desc_ready_o), 64'd1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] idx_before;
        int          n;
        logic [15:0] rc;
        logic [31:0] rz;

        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single strided descriptor, done echoed 10 cycles after each start.
        resp_dly = 10;
        send(64'h1000, 64'h4000, 16'd3, 32'd256, 1'b0, 1'b0);
        wait_idle();

        // Second descriptor accepted while the first is running.
        resp_dly = 6;
        send(64'h2000, 64'h100, 16'd2, 32'd16, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_busy", 64'(busy_o), 64'd1);
        chk("b2b_ready", 64'(desc_ready_o), 64'd1);
        send(64'h8_0000, 64'h40, 16'd3, 32'd8, 1'b1, 1'b0);
        wait_idle();

        // Empty descriptors: no job, done one cycle after the load.
        send(64'hABC0, 64'h10, 16'd0, 32'd4, 1'b0, 1'b1);
        wait_idle();
        send(64'hABC0, 64'h10, 16'd3, 32'd0, 1'b0, 1'b1);
        wait_idle();

        // Address wrap across 2^64.
        resp_dly = 3;
        send(64'hFFFF_FFFF_FFFF_F000, 64'h1000, 16'd2, 32'd32, 1'b0, 1'b0);
        wait_idle();

        // Spurious done in IDLE.
        idx_before = chunk_idx_o;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        chk("spur_idle_busy", 64'(busy_o), 64'd0);
        chk("spur_idle_idx", 64'(chunk_idx_o), 64'(idx_before));

        // Spurious done during START must not advance the address.
        resp_dly = 5;
        send(64'h30_0000, 64'h800, 16'd2, 32'd64, 1'b0, 1'b0);
        n = 0;
        while (!ctrl_start_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("spur_start_seen", 64'(ctrl_start_o), 64'd1);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("spur_start_idx", 64'(chunk_idx_o), 64'd0);
        chk("spur_start_busy", 64'(busy_o), 64'd1);
        wait_idle();

        // Randomised descriptor stream against the job-list model.
        resp_dly = 0;
        for (int k = 0; k < 40; k++) begin
            rc = 16'($urandom_range(0, 4));
            rz = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
            send({$urandom, $urandom}, {$urandom, $urandom}, rc, rz, 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        // Reset while chunk 1 of 4 is outstanding, with a descriptor pending.
        resp_dly = 30;
        send(64'h50_0000, 64'h1_0000, 16'd4, 32'd128, 1'b0, 1'b0);
        n = 0;
        while (!(ctrl_start_o && chunk_idx_o == 16'd1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst_chunk1_start", 64'(chunk_idx_o), 64'd1);
        send(64'h60_0000, 64'h20, 16'd2, 32'd4, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_pending_held", 64'(desc_ready_o), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("midrst");
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_busy", 64'(busy_o), 64'd0);
        chk("post_rst_ready", 64'(desc_ready_o), 64'd1);

        chk("exp_left", 64'(exp_q.size()), 64'd0);
        chk("ddone_left", 64'(pend_ddone), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
